number_to_digits_seq: RTL and testbench

NUMBER_TO_DIGITS_SEQ -- requirements
Module: number_to_digits_seq

---
 rtl/number_to_digits_seq.sv | 137 +++++++++++++
 tb/tb_number_to_digits_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/number_to_digits_seq.sv
// number_to_digits_seq: sequential binary-to-ASCII-decimal converter.
// It uses double-dabble and handles one input bit per clock, MSB first.
// The BCD accumulator keeps DIGITS digits. Any carry out of the top digit
// sets a sticky overflow flag, so the result is number mod 10^DIGITS.
// Optional leading-zero blanking replaces leading zeros with spaces.
//
// Ports:
//   clock    - single clock, rising edge
//   reset    - synchronous, active-high
//   start    - conversion request, sampled only while busy=0
//   number   - WIDTH-bit unsigned value, captured on the accepting edge
//   blank_en - leading-zero blanking, captured on the accepting edge
//   busy     - high while shifting
//   done     - one-cycle pulse when digits/overflow are updated
//   overflow - last converted number was >= 10^DIGITS
//   digits   - ASCII digits; byte i holds the 10^i digit

// Per-digit double-dabble correction: add 3 when the digit is 5 or more, so
// the following left shift carries into the next decade.
module ntd_dabble_digit (
   input  logic [3:0] bcd_in,
   output logic [3:0] bcd_out
);
   assign bcd_out = (bcd_in >= 4'd5) ? bcd_in + 4'd3 : bcd_in;
endmodule

module number_to_digits_seq #(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 6
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      number,
   input  logic                  blank_en,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [8*DIGITS-1:0]   digits
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state;
   logic [WIDTH-1:0]  shreg;
   logic              blank_q;
   logic [BW-1:0]     bcd;
   logic              sticky;
   logic [CW-1:0]     cnt;

   logic [BW-1:0]     adj;
   logic [BW-1:0]     bcd_next;
   logic              carry;
   logic [8*DIGITS-1:0] ascii;

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_dig
         ntd_dabble_digit u_adj (
            .bcd_in  (bcd[4*g +: 4]),
            .bcd_out (adj[4*g +: 4])
         );
      end
   endgenerate

   // The bit shifted out of the top digit stands for 10^DIGITS and is
   // dropped here. It is only recorded through the sticky overflow flag.
   assign carry    = adj[BW-1];
   assign bcd_next = {adj[BW-2:0], shreg[WIDTH-1]};

   // Encode the post-shift accumulator, so the final shift edge can write
   // the result directly. Blanking stops at the first nonzero digit from
   // the top. Byte 0 is always shown.
   always_comb begin
      logic       seen;
      logic [3:0] d;
      ascii = '0;
      seen  = 1'b0;
      d     = 4'd0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         d = bcd_next[4*i +: 4];
         if (d != 4'd0) seen = 1'b1;
         if (blank_q && !seen && (i != 0))
            ascii[8*i +: 8] = 8'h20;
         else
            ascii[8*i +: 8] = {4'h3, d};
      end
   end

   assign busy = (state == SHIFT);

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         shreg    <= '0;
         blank_q  <= 1'b0;
         bcd      <= '0;
         sticky   <= 1'b0;
         cnt      <= '0;
         done     <= 1'b0;
         overflow <= 1'b0;
         digits   <= {DIGITS{8'h30}};
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  shreg   <= number;
                  blank_q <= blank_en;
                  bcd     <= '0;
                  sticky  <= 1'b0;
                  cnt     <= '0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               shreg  <= shreg << 1;
               bcd    <= bcd_next;
               sticky <= sticky | carry;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  digits   <= ascii;
                  overflow <= sticky | carry;
                  done     <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_number_to_digits_seq.sv
// Directed bench for number_to_digits_seq.
// The default instance is 32-bit with 6 digits. The small instance is
// 8-bit with 3 digits.
module tb_number_to_digits_seq;

   logic        clock = 1'b0;
   logic        reset;
   logic        start_a, blank_a;
   logic [31:0] num_a;
   logic        busy_a, done_a, ovf_a;
   logic [47:0] dig_a;
   logic        start_b, blank_b;
   logic [7:0]  num_b;
   logic        busy_b, done_b, ovf_b;
   logic [23:0] dig_b;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   number_to_digits_seq u_dut (
      .clock(clock), .reset(reset), .start(start_a), .number(num_a),
      .blank_en(blank_a), .busy(busy_a), .done(done_a), .overflow(ovf_a),
      .digits(dig_a)
   );

   number_to_digits_seq #(.WIDTH(8), .DIGITS(3)) u_small (
      .clock(clock), .reset(reset), .start(start_b), .number(num_b),
      .blank_en(blank_b), .busy(busy_b), .done(done_b), .overflow(ovf_b),
      .digits(dig_b)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Pulse start on instance A; returns after the accepting edge.
   task automatic start_a_conv(input logic [31:0] n, input logic b);
      @(posedge clock); #1;
      start_a = 1'b1; num_a = n; blank_a = b;
      @(posedge clock); #1;
      start_a = 1'b0;
   endtask

   // Count edges until done_a is seen (bounded).
   task automatic wait_done_a(input string name, output int n);
      n = 0;
      do begin
         @(posedge clock); n++; #1;
      end while (!done_a && n < 200);
      if (!done_a) check({name, " timeout"}, 64'(n), 64'd32);
   endtask

   typedef struct {
      logic [31:0] num;
      logic        blank;
      logic [47:0] exp_dig;
      logic        exp_ovf;
      string       name;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int n, n2;
      logic saw_done;

      vecs[0] = '{32'd123456,     1'b0, "123456", 1'b0, "v123456"};
      vecs[1] = '{32'd42,         1'b1, "    42", 1'b0, "v42blank"};
      vecs[2] = '{32'd0,          1'b1, "     0", 1'b0, "v0blank"};
      vecs[3] = '{32'd1234567,    1'b0, "234567", 1'b1, "v1234567"};
      vecs[4] = '{32'd999999,     1'b0, "999999", 1'b0, "v999999"};
      vecs[5] = '{32'd1000000,    1'b1, "     0", 1'b1, "v1e6blank"};
      vecs[6] = '{32'd1000042,    1'b1, "    42", 1'b1, "v1000042blank"};
      vecs[7] = '{32'hFFFFFFFF,   1'b0, "967295", 1'b1, "vFFFFFFFF"};

      reset = 1'b1; start_a = 1'b0; blank_a = 1'b0; num_a = '0;
      start_b = 1'b0; blank_b = 1'b0; num_b = '0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      check("rst_busy", 64'(busy_a), 64'd0);
      check("rst_done", 64'(done_a), 64'd0);
      check("rst_ovf",  64'(ovf_a),  64'd0);
      check("rst_dig",  64'(dig_a),  64'("000000"));

      foreach (vecs[k]) begin
         start_a_conv(vecs[k].num, vecs[k].blank);
         wait_done_a(vecs[k].name, n);
         check({vecs[k].name, "_lat"},  64'(n),      64'd32);
         check({vecs[k].name, "_dig"},  64'(dig_a),  64'(vecs[k].exp_dig));
         check({vecs[k].name, "_ovf"},  64'(ovf_a),  64'(vecs[k].exp_ovf));
         check({vecs[k].name, "_busy"}, 64'(busy_a), 64'd0);
      end

      // Start and number changes during busy are ignored. Start is held high
      // and is accepted in the done cycle.
      start_a_conv(32'd777, 1'b0);
      n = 0;
      do begin
         @(posedge clock); n++; #1;
         if (n == 5) begin start_a = 1'b1; num_a = 32'd12345; end
      end while (!done_a && n < 200);
      check("b2b_lat1", 64'(n), 64'd32);
      check("b2b_dig1", 64'(dig_a), 64'("000777"));
      check("b2b_idle_in_done", 64'(busy_a), 64'd0);
      n2 = 0;
      do begin
         @(posedge clock); n2++; #1;
         if (n2 == 1) begin
            start_a = 1'b0;
            check("b2b_accept", 64'(busy_a), 64'd1);
            check("b2b_no_dbl_done", 64'(done_a), 64'd0);
         end
         if (n2 == 10) check("b2b_hold_dig", 64'(dig_a), 64'("000777"));
      end while (!done_a && n2 < 200);
      check("b2b_lat2", 64'(n2), 64'd33);
      check("b2b_dig2", 64'(dig_a), 64'("012345"));

      // A conversion that overflows, then a conversion aborted by reset.
      start_a_conv(32'hFFFFFFFF, 1'b0);
      wait_done_a("pre_rst", n);
      check("pre_rst_ovf", 64'(ovf_a), 64'd1);
      start_a_conv(32'd555, 1'b0);
      repeat (9) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      check("abort_busy", 64'(busy_a), 64'd0);
      check("abort_dig",  64'(dig_a),  64'("000000"));
      check("abort_ovf",  64'(ovf_a),  64'd0);
      saw_done = 1'b0;
      repeat (40) begin
         @(posedge clock); #1;
         if (done_a) saw_done = 1'b1;
      end
      check("abort_no_done", 64'(saw_done), 64'd0);

      // Reset and start on the same edge: no conversion starts.
      reset = 1'b1; start_a = 1'b1; num_a = 32'd9;
      @(posedge clock); #1 reset = 1'b0; start_a = 1'b0;
      check("rst_start_busy", 64'(busy_a), 64'd0);
      @(posedge clock); #1;
      check("rst_start_busy2", 64'(busy_a), 64'd0);

      // Small configuration: 8-bit input, 3 digits.
      begin
         logic [7:0]  snum[3]  = '{8'd255, 8'd7, 8'd0};
         logic        sblk[3]  = '{1'b0, 1'b1, 1'b0};
         logic [23:0] sexp[3]  = '{"255", "  7", "000"};
         for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            start_b = 1'b1; num_b = snum[k]; blank_b = sblk[k];
            @(posedge clock); #1 start_b = 1'b0;
            n = 0;
            do begin
               @(posedge clock); n++; #1;
            end while (!done_b && n < 100);
            check("small_lat", 64'(n),     64'd8);
            check("small_dig", 64'(dig_b), 64'(sexp[k]));
            check("small_ovf", 64'(ovf_b), 64'd0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
